// File: rtl/system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : system_sysid_checker
// Purpose  : Avalon-MM read master that fetches the sysid word (addr 0) and
//            build timestamp (addr 1) and compares them with expected values.
// Revision : 1.0 - initial release
// ============================================================================
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1392326789,
  parameter int          TIMEOUT_CYCLES     = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_ID  = 3'd1,
    S_WAIT_ID = 3'd2,
    S_REQ_TS  = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] c_limit = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_addr;
  logic        r_read;

  logic w_expire;
  logic w_id_eq;
  logic w_ts_eq;

  assign w_expire = (r_cnt == c_limit);
  assign w_id_eq  = (avm_readdata == EXPECTED_ID);
  assign w_ts_eq  = (avm_readdata == EXPECTED_TIMESTAMP);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
      r_addr     <= 1'b0;
      r_read     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !r_done) begin
            r_state    <= S_REQ_ID;
            r_busy     <= 1'b1;
            r_read     <= 1'b1;
            r_addr     <= 1'b0;
            r_cnt      <= 16'd0;
            r_pass     <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        S_REQ_ID, S_REQ_TS: begin
          r_cnt <= r_cnt + 16'd1;
          // An acceptance on the final allowed cycle still leaves no time for data.
          if (w_expire) begin
            r_state   <= S_DONE;
            r_read    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
          end else if (!avm_waitrequest) begin
            r_state <= (r_state == S_REQ_ID) ? S_WAIT_ID : S_WAIT_TS;
            r_read  <= 1'b0;
          end
        end
        S_WAIT_ID: begin
          r_cnt <= r_cnt + 16'd1;
          if (avm_readdatavalid) begin
            r_id_value <= avm_readdata;
            r_id_match <= w_id_eq;
            r_state    <= S_REQ_TS;
            r_read     <= 1'b1;
            r_addr     <= 1'b1;
            r_cnt      <= 16'd0;
          end else if (w_expire) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        S_WAIT_TS: begin
          r_cnt <= r_cnt + 16'd1;
          if (avm_readdatavalid) begin
            r_ts_value <= avm_readdata;
            r_ts_match <= w_ts_eq;
            r_pass     <= r_id_match && w_ts_eq;
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (w_expire) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;
  assign avm_address = r_addr;
  assign avm_read    = r_read;

endmodule
`default_nettype wire

// File: tb/tb_system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_system_sysid_checker
// Purpose  : Directed self-checking bench with a simple sysid responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_system_sysid_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;
  logic        avm_address, avm_read;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;

  // Responder state (updated on the falling edge)
  logic        rsp_wr = 1'b0, rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'd0;
  logic [31:0] id_word = 32'd0, ts_word = 32'd1392326789;
  int          n_stall = 0, stall_cnt = 0, accepts = 0, stable_err = 0;
  logic        drop_ts = 1'b0, pend = 1'b0, pend_addr = 1'b0;
  logic        prev_stall = 1'b0, prev_addr = 1'b0;

  // Manual override of the slave side
  logic        man_en = 1'b0, man_wr = 1'b0, man_valid = 1'b0;
  logic [31:0] man_data = 32'd0;

  int checks = 0, errors = 0;
  int k, nbusy, acc0;

  assign avm_waitrequest   = man_en ? man_wr    : rsp_wr;
  assign avm_readdatavalid = man_en ? man_valid : rsp_valid;
  assign avm_readdata      = man_en ? man_data  : rsp_data;

  system_sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(32'd1392326789),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .id_match         (id_match),
    .ts_match         (ts_match),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      rsp_wr = 1'b0; rsp_valid = 1'b0; pend = 1'b0; stall_cnt = 0; prev_stall = 1'b0;
    end else begin
      rsp_valid = 1'b0;
      if (pend) begin
        rsp_valid = 1'b1;
        rsp_data  = pend_addr ? ts_word : id_word;
        pend      = 1'b0;
      end
      if (prev_stall && (!avm_read || avm_address != prev_addr)) stable_err++;
      if (avm_read) begin
        if (stall_cnt < n_stall) begin
          rsp_wr = 1'b1;
          stall_cnt++;
        end else begin
          rsp_wr    = 1'b0;
          stall_cnt = 0;
          accepts++;
          if (!(avm_address && drop_ts)) begin
            pend      = 1'b1;
            pend_addr = avm_address;
          end
        end
      end else begin
        rsp_wr = 1'b0;
      end
      prev_stall = avm_read && rsp_wr;
      prev_addr  = avm_address;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start, optionally re-pulses it at cycle 'extra', returns the done cycle.
  task automatic run(input int extra, output int kk, output int nb);
    nb = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    kk = 1;
    while (kk < 200) begin
      if (busy) nb++;
      if (done) break;
      start = (kk == extra);
      @(negedge clock);
      kk++;
    end
    start = 1'b0;
    chk("run_bound", 32'(kk < 200), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_flags", {26'd0, done, pass, id_match, ts_match, timeout, avm_read}, 32'd0);
    chk("rst_addr",  {31'd0, avm_address}, 32'd0);
    chk("rst_idv",   id_value, 32'd0);
    chk("rst_tsv",   ts_value, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Nominal check, zero wait, latency 1
    acc0 = accepts;
    run(0, k, nbusy);
    chk("t1_cycle", k, 32'd5);
    chk("t1_busycyc", nbusy, 32'd4);
    chk("t1_flags", {29'd0, pass, id_match, ts_match}, 32'd7);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    chk("t1_idv", id_value, 32'd0);
    chk("t1_tsv", ts_value, 32'd1392326789);
    chk("t1_accepts", accepts - acc0, 32'd2);
    @(negedge clock);
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_pass_held", {31'd0, pass}, 32'd1);

    // Timestamp mismatch
    ts_word = 32'd1392326790;
    run(0, k, nbusy);
    chk("t2_flags", {29'd0, pass, id_match, ts_match}, 32'd2);
    chk("t2_tsv", ts_value, 32'd1392326790);
    ts_word = 32'd1392326789;

    // Three stall cycles on each read
    n_stall = 3; acc0 = accepts; stable_err = 0;
    run(0, k, nbusy);
    chk("t3_cycle", k, 32'd11);
    chk("t3_stable", stable_err, 32'd0);
    chk("t3_accepts", accepts - acc0, 32'd2);
    chk("t3_pass", {31'd0, pass}, 32'd1);
    n_stall = 0;

    // No data for word 1 -> timeout 8 cycles after REQ_TS entry (cycle 3)
    drop_ts = 1'b1;
    run(0, k, nbusy);
    chk("t4_cycle", k, 32'd11);
    chk("t4_read", {31'd0, avm_read}, 32'd0);
    chk("t4_flags", {28'd0, timeout, pass, id_match, ts_match}, 32'b1010);
    drop_ts = 1'b0;

    // Extra start while busy is ignored; flags from the timeout run are cleared
    run(2, k, nbusy);
    chk("t5_cycle", k, 32'd5);
    chk("t5_flags", {28'd0, timeout, pass, id_match, ts_match}, 32'b0111);
    // start coinciding with done is ignored
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_no_restart", {30'd0, busy, avm_read}, 32'd0);
    // spurious readdatavalid in DONE/IDLE
    man_en = 1'b1; man_valid = 1'b1; man_data = 32'hDEADBEEF;
    @(negedge clock); man_valid = 1'b0;
    @(negedge clock);
    chk("t5_spur_idv", id_value, 32'd0);
    chk("t5_spur_tsv", ts_value, 32'd1392326789);

    // Reset in WAIT_ID then a late data beat
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;     // cycle 1: REQ_ID, accepted
    @(negedge clock);                   // cycle 2: WAIT_ID
    chk("t6_in_wait", {30'd0, busy, avm_read}, 32'b10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; man_valid = 1'b1;
    chk("t6_rst_out", {27'd0, busy, done, pass, avm_read, timeout}, 32'd0);
    chk("t6_rst_tsv", ts_value, 32'd0);
    @(negedge clock); man_valid = 1'b0;
    @(negedge clock);
    chk("t6_late_idv", id_value, 32'd0);
    chk("t6_late_busy", {31'd0, busy}, 32'd0);
    man_en = 1'b0;
    run(0, k, nbusy);
    chk("t6_rerun_cycle", k, 32'd5);
    chk("t6_rerun_pass", {29'd0, pass, id_match, ts_match}, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
